ov7670_frame_writer: RTL and testbench

Parametrised OV7670 capture front end that replaces the fixed 640x480 capture path feeding the dual-port frame buffers. It runs in the camera pixel-clock domain, pairs RGB565 bytes into pixels, and optionally decimates by 1, 2 or 4 in both axes. It converts pixels to the configured frame-buffer width and emits a write strobe, address and data for the buffer's port A. Per-frame freeze, frame counting and overflow/short-frame flags are added for the pause and resolution-change modes.

---
 rtl/ov7670_pkg.sv | 39 +++
 rtl/ov7670_byte_pair.sv | 43 ++++
 rtl/ov7670_frame_writer.sv | 158 +++++++++++++++
 tb/tb_ov7670_frame_writer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared types and helpers for the OV7670 capture front end.
package ov7670_pkg;

    // Capture FSM states.
    typedef enum logic [1:0] {
        ST_WAIT_VS    = 2'd0,  // wait for vsync high
        ST_WAIT_FRAME = 2'd1,  // wait for vsync falling edge
        ST_CAPTURE    = 2'd2,  // frame is being written
        ST_SKIP       = 2'd3   // frame is frozen, nothing written
    } state_t;

    // RGB565 field widths.
    localparam int RGB565_R_W = 5;
    localparam int RGB565_G_W = 6;
    localparam int RGB565_B_W = 5;

    typedef struct packed {
        logic [RGB565_R_W-1:0] r;
        logic [RGB565_G_W-1:0] g;
        logic [RGB565_B_W-1:0] b;
    } rgb565_t;

    // Reduce an RGB565 pixel to the frame-buffer format, right-aligned in 16 bits.
    function automatic logic [15:0] rgb565_to_pix(input logic [15:0] pix, input int pix_w);
        rgb565_t c;
        c = rgb565_t'(pix);
        case (pix_w)
            8:       return {8'h00, c.r[4:2], c.g[5:3], c.b[4:3]};
            12:      return {4'h0, c.r[4:1], c.g[5:2], c.b[4:1]};
            default: return pix;
        endcase
    endfunction

    // Pixels written per frame for a given log2 decimation factor.
    function automatic int unsigned exp_pixels(input int h_res, input int v_res, input logic [1:0] k);
        return int'(h_res >> k) * int'(v_res >> k);
    endfunction

endpackage

// File: rtl/ov7670_byte_pair.sv
// Pairs OV7670 bytes into RGB565 pixels: high byte first, low byte completes
// the pixel. pix_valid and line_end are combinational on the current inputs so
// the top can register its write in the same edge that samples the low byte.
module ov7670_byte_pair (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        href,
    input  logic [7:0]  din,
    output logic        pix_valid,
    output logic [15:0] pix,
    output logic        line_end
);

    logic       have_hi;
    logic [7:0] hi_byte;
    logic       href_q;

    // Track byte phase; a dangling high byte is dropped when href falls.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            have_hi <= 1'b0;
            hi_byte <= 8'h00;
            href_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            href_q <= href;
            if (!href) begin
                have_hi <= 1'b0;
            end else if (have_hi) begin
                have_hi <= 1'b0;
            end else begin
                have_hi <= 1'b1;
                hi_byte <= din;
            end
        end
    end

    assign pix_valid = href & have_hi;
    assign pix       = {hi_byte, din};
    assign line_end  = href_q & ~href;

endmodule

// File: rtl/ov7670_frame_writer.sv
// OV7670 capture front end: frame FSM, decimation, address generation,
// pixel conversion and per-frame status for frame-buffer port A.
module ov7670_frame_writer
    import ov7670_pkg::*;
#(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 12
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        din,
    input  logic [1:0]        decim,
    input  logic              freeze,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              ovf,
    output logic              short_frame
);

    state_t          state;
    logic [1:0]      k;          // frame-stable decimation
    logic [1:0]      k_in;       // decim with 3 folded onto 2
    logic [1:0]      k_mask;
    logic [1:0]      x_cnt;      // only the low bits matter for decimation
    logic [1:0]      y_cnt;
    logic [ADDR_W:0] n_exp;      // pixels expected this frame
    logic [ADDR_W:0] addr_last;
    logic [ADDR_W:0] wr_cnt;     // pixels written this frame
    logic            pix_valid;
    logic [15:0]     pix;
    logic            line_end;
    logic            kept;
    logic            at_limit;
    logic            do_write;
    logic            do_drop;
    logic            frame_start;
    logic            frame_end;

    ov7670_byte_pair u_byte_pair (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .href      (href),
        .din       (din),
        .pix_valid (pix_valid),
        .pix       (pix),
        .line_end  (line_end)
    );

    assign k_in = (decim == 2'd3) ? 2'd2 : decim;

    // Decimation mask from the latched factor.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        k_mask = 2'b00;
        case (k)
            2'd0:    k_mask = 2'b00;
            2'd1:    k_mask = 2'b01;
            default: k_mask = 2'b11;
        endcase
    end

    assign kept        = ((x_cnt & k_mask) == 2'b00) && ((y_cnt & k_mask) == 2'b00);
    assign at_limit    = (wr_cnt == n_exp);
    assign addr_last   = n_exp - (ADDR_W+1)'(1);
    assign do_write    = (state == ST_CAPTURE) && pix_valid && kept && !at_limit;
    assign do_drop     = (state == ST_CAPTURE) && pix_valid && kept && at_limit;
    assign frame_start = (state == ST_WAIT_FRAME) && !vsync;
    assign frame_end   = (state == ST_CAPTURE) && vsync;

    // Frame FSM and frame-stable settings.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT_VS;
            k     <= 2'd0;
            n_exp <= '0;
        end else begin
            case (state)
                ST_WAIT_VS: begin
                    if (vsync) state <= ST_WAIT_FRAME;
                end
                ST_WAIT_FRAME: begin
                    if (!vsync) begin
                        state <= freeze ? ST_SKIP : ST_CAPTURE;
                        k     <= k_in;
                        n_exp <= (ADDR_W+1)'(exp_pixels(H_RES, V_RES, k_in));
                    end
                end
                default: begin
                    if (vsync) state <= ST_WAIT_FRAME;
                end
            endcase
        end
    end

    // Pixel position within the frame (modulo 4).
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= 2'd0;
            y_cnt <= 2'd0;
        end else if (frame_start) begin
            x_cnt <= 2'd0;
            y_cnt <= 2'd0;
        end else if (pix_valid) begin
            x_cnt <= x_cnt + 2'd1;
        end else if (line_end) begin
            x_cnt <= 2'd0;
            y_cnt <= y_cnt + 2'd1;
        end
    end

    // Write port: one-cycle strobe, address advances after each write and holds at N-1.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_cnt  <= '0;
        end else begin
            wr_en <= do_write;
            if (do_write) wr_data <= PIX_W'(rgb565_to_pix(pix, PIX_W));
            if (frame_start) begin
                wr_addr <= '0;
                wr_cnt  <= '0;
            end else begin
                if (wr_en && ({1'b0, wr_addr} != addr_last)) wr_addr <= wr_addr + 1'b1;
                if (do_write) wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Frame status: completion pulse, counter and sticky per-frame flags.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done  <= 1'b0;
            frame_cnt   <= 8'd0;
            ovf         <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) frame_cnt <= frame_cnt + 8'd1;
            if (frame_start) begin
                ovf         <= 1'b0;
                short_frame <= 1'b0;
            end else begin
                if (do_drop) ovf <= 1'b1;
                if (frame_end && ((wr_cnt + (ADDR_W+1)'(do_write)) < n_exp)) short_frame <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_frame_writer.sv
// Directed bench for ov7670_frame_writer on a scaled 8x4 sensor, with 8-, 12-
// and 16-bit output instances sharing the same stimulus.
module tb_ov7670_frame_writer;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 5;

    typedef struct {
        logic [15:0] pix;
        logic [11:0] e12;
        logic [7:0]  e8;
    } vec_t;

    vec_t tbl[6];

    logic          pclk = 1'b0;
    logic          rst_n = 1'b1;
    logic          vsync, href, freeze;
    logic [7:0]    din;
    logic [1:0]    decim;

    logic          wr_en, frame_done, ovf, short_frame;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic [7:0]    frame_cnt;

    logic          en8, fd8, ovf8, sf8, en16, fd16, ovf16, sf16;
    logic [AW-1:0] addr8, addr16;
    logic [7:0]    d8, fc8, fc16;
    logic [15:0]   d16;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] q_addr[$];
    logic [11:0]   q_d12[$];
    logic [7:0]    q_d8[$];
    logic [15:0]   q_d16[$];
    int            fd_cnt = 0;
    int            twin_mis = 0;

    ov7670_frame_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .PIX_W(12)) dut (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .din(din),
        .decim(decim), .freeze(freeze), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .ovf(ovf), .short_frame(short_frame)
    );

    ov7670_frame_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .PIX_W(8)) dut8 (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .din(din),
        .decim(decim), .freeze(freeze), .wr_en(en8), .wr_addr(addr8),
        .wr_data(d8), .frame_done(fd8), .frame_cnt(fc8),
        .ovf(ovf8), .short_frame(sf8)
    );

    ov7670_frame_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .PIX_W(16)) dut16 (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .din(din),
        .decim(decim), .freeze(freeze), .wr_en(en16), .wr_addr(addr16),
        .wr_data(d16), .frame_done(fd16), .frame_cnt(fc16),
        .ovf(ovf16), .short_frame(sf16)
    );

    always #5 pclk = ~pclk;

    // Write monitor, sampled on the falling edge.
    always @(negedge pclk) begin
        if (wr_en) begin
            q_addr.push_back(wr_addr);
            q_d12.push_back(wr_data);
            q_d8.push_back(d8);
            q_d16.push_back(d16);
        end
        if (frame_done) fd_cnt++;
        if ({en8, addr8, fd8, fc8, ovf8, sf8} !== {wr_en, wr_addr, frame_done, frame_cnt, ovf, short_frame} ||
            {en16, addr16, fd16, fc16, ovf16, sf16} !== {wr_en, wr_addr, frame_done, frame_cnt, ovf, short_frame})
            twin_mis++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pix_of(input int x, input int y);
        if (y == 0 && x < 6) return tbl[x].pix;
        return 16'(16'h0100 + x + 16 * y);
    endfunction

    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        @(negedge pclk);
        vsync = v;
        href  = h;
        din   = d;
    endtask

    task automatic send_pix(input logic [15:0] p);
        drive(1'b0, 1'b1, p[15:8]);
        drive(1'b0, 1'b1, p[7:0]);
    endtask

    task automatic clear_mon();
        q_addr.delete();
        q_d12.delete();
        q_d8.delete();
        q_d16.delete();
        fd_cnt = 0;
    endtask

    // One frame: vsync pulse, lines of pixels (optionally one trailing byte), vsync high.
    task automatic run_frame(input int lines, input bit odd, input logic [1:0] dec,
                             input logic frz, input logic frz_mid);
        decim  = dec;
        freeze = frz;
        repeat (2) drive(1'b1, 1'b0, 8'h00);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        for (int y = 0; y < lines; y++) begin
            if (y == 1) begin
                freeze = frz_mid;
                decim  = 2'd0;
            end
            for (int x = 0; x < H; x++) send_pix(pix_of(x, y));
            if (odd) drive(1'b0, 1'b1, 8'h5A);
            repeat (3) drive(1'b0, 1'b0, 8'h00);
        end
        repeat (4) drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic check_frame(input string name, input int exp_n, input int k, input int fd_exp,
                               input int cnt_exp, input logic ovf_exp, input logic sf_exp);
        int per, na, nd;
        per = H >> k;
        na  = 0;
        nd  = 0;
        check({name, "_writes"}, q_addr.size(), exp_n);
        for (int i = 0; i < q_addr.size(); i++) begin
            if (q_addr[i] !== AW'(i)) na++;
            if (q_d16[i] !== pix_of((i % per) << k, (i / per) << k)) nd++;
        end
        check({name, "_addr_seq_errs"}, na, 0);
        check({name, "_data_seq_errs"}, nd, 0);
        check({name, "_frame_done"}, fd_cnt, fd_exp);
        check({name, "_frame_cnt"}, frame_cnt, cnt_exp);
        check({name, "_ovf"}, ovf, ovf_exp);
        check({name, "_short"}, short_frame, sf_exp);
        clear_mon();
    endtask

    initial begin
        tbl[0] = '{16'hF81F, 12'hF0F, 8'hE3};
        tbl[1] = '{16'h07E0, 12'h0F0, 8'h1C};
        tbl[2] = '{16'h0000, 12'h000, 8'h00};
        tbl[3] = '{16'hFFFF, 12'hFFF, 8'hFF};
        tbl[4] = '{16'h1234, 12'h14A, 8'h0A};
        tbl[5] = '{16'hA5C3, 12'hAB1, 8'hB4};

        vsync  = 1'b0;
        href   = 1'b0;
        din    = 8'h00;
        decim  = 2'd0;
        freeze = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_flags", {ovf, short_frame}, 0);
        rst_n = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 8'h00);

        // Full frame, no decimation; first line carries the conversion table.
        run_frame(V, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("tbl%0d_rgb444", i), (i < q_d12.size()) ? q_d12[i] : 12'hxxx, tbl[i].e12);
            check($sformatf("tbl%0d_rgb332", i), (i < q_d8.size()) ? q_d8[i] : 8'hxx, tbl[i].e8);
            check($sformatf("tbl%0d_rgb565", i), (i < q_d16.size()) ? q_d16[i] : 16'hxxxx, tbl[i].pix);
        end
        check_frame("full", 32, 0, 1, 1, 1'b0, 1'b0);

        run_frame(V, 1'b0, 2'd1, 1'b0, 1'b0);
        check_frame("decim1", 8, 1, 1, 2, 1'b0, 1'b0);

        run_frame(V, 1'b0, 2'd0, 1'b1, 1'b0);
        check_frame("frozen", 0, 0, 0, 2, 1'b0, 1'b0);

        run_frame(V, 1'b0, 2'd0, 1'b0, 1'b1);
        check_frame("after_freeze", 32, 0, 1, 3, 1'b0, 1'b0);

        run_frame(V, 1'b1, 2'd0, 1'b0, 1'b0);
        check_frame("odd_line", 32, 0, 1, 4, 1'b0, 1'b0);

        run_frame(V + 1, 1'b0, 2'd0, 1'b0, 1'b0);
        check("ovf_addr_hold", wr_addr, 31);
        check_frame("overflow", 32, 0, 1, 5, 1'b1, 1'b0);

        run_frame(V - 1, 1'b0, 2'd0, 1'b0, 1'b0);
        check_frame("short", 24, 0, 1, 6, 1'b0, 1'b1);

        run_frame(V, 1'b0, 2'd3, 1'b0, 1'b0);
        check_frame("decim3", 2, 2, 1, 7, 1'b0, 1'b0);

        // Reset in the middle of a line, after a dangling high byte.
        repeat (2) drive(1'b1, 1'b0, 8'h00);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        send_pix(16'h1234);
        send_pix(16'h5678);
        drive(1'b0, 1'b1, 8'hAA);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {wr_en, wr_addr, wr_data, frame_done, ovf, short_frame}, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        @(negedge pclk);
        rst_n = 1'b1;
        clear_mon();
        for (int i = 0; i < 3; i++) send_pix(16'hF81F);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        check("rst_no_write", q_addr.size(), 0);

        repeat (2) drive(1'b1, 1'b0, 8'h00);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        send_pix(16'hF81F);
        drive(1'b0, 1'b0, 8'h00);
        check("resume_wr_en", wr_en, 1);
        check("resume_wr_addr", wr_addr, 0);
        check("resume_wr_data", wr_data, 12'hF0F);
        drive(1'b0, 1'b0, 8'h00);
        check("resume_strobe_len", wr_en, 0);
        check("resume_addr_inc", wr_addr, 1);
        drive(1'b1, 1'b0, 8'h00);
        check("fd_before", frame_done, 0);
        drive(1'b1, 1'b0, 8'h00);
        check("fd_pulse", frame_done, 1);
        check("fd_frame_cnt", frame_cnt, 1);
        check("fd_short", short_frame, 1);
        drive(1'b1, 1'b0, 8'h00);
        check("fd_one_cycle", frame_done, 0);
        check("twin_instances_agree", twin_mis, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
